// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 controller/sequencer.
// Runs the T-state machine from fetch (T1..T3) through the variable-length
// execute phase (T4..T7). It generates every per-cycle control strobe for
// PC, MAR, RAM, IR, A, B, the ALU and the output register. HLT parks the
// machine in HALT until reset.
// Optional feature: define SAP_JMP_EN to enable the JMP instruction.
// Without it, JMP decodes as a NOP and pc_load is constant 0.

module controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_JMP = 4'b0011,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       ir_drive,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_in,
    output logic [2:0] t_state,
    output logic       halted
);

    typedef enum logic [2:0] {
        HALT = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        T6   = 3'd6,
        T7   = 3'd7
    } state_t;

`ifdef SAP_JMP_EN
    localparam bit JMP_EN = 1'b1;
`else
    // JMP falls through to the NOP path, so pc_load can never be raised.
    localparam bit JMP_EN = 1'b0;
`endif

    state_t state_q;
    state_t state_d;

    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_arith;
    logic is_jmp;
    logic is_out;
    logic is_hlt;

    // Opcode decode. It is only consulted in T4..T7, when the IR is stable.
    always_comb begin
        is_lda   = (opcode == OP_LDA);
        is_add   = (opcode == OP_ADD);
        is_sub   = (opcode == OP_SUB);
        is_arith = is_add | is_sub;
        is_jmp   = JMP_EN && (opcode == OP_JMP);
        is_out   = (opcode == OP_OUT);
        is_hlt   = (opcode == OP_HLT);
    end

    // Next-state sequencing. Each instruction returns to T1 after its last execute state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = T4;
            T4: begin
                if (is_lda || is_arith || is_jmp) state_d = T5;
                else if (is_hlt)                  state_d = HALT;
                else                              state_d = T1;
            end
            T5: begin
                if (is_lda || is_arith) state_d = T6;
                else                    state_d = T1;
            end
            T6: begin
                if (is_arith) state_d = T7;
                else          state_d = T1;
            end
            T7:      state_d = T1;
            HALT:    state_d = HALT;
            default: state_d = T1;
        endcase
    end

    // State register. A synchronous reset restarts fetch from any state, including HALT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobe decode. Reset masks every strobe in the same cycle, so an
    // interrupted execute step never reaches the datapath.
    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mar_in   = 1'b0;
        ram_out  = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        ir_drive = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_in   = 1'b0;
        if (!reset) begin
            case (state_q)
                T1: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                T2: begin
                    pc_inc = 1'b1;
                end
                T3: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                end
                T4: begin
                    // The IR bus output is registered, so the operand is
                    // requested here, one state ahead of its use in T5.
                    if (is_lda || is_arith || is_jmp) begin
                        ir_out = 1'b1;
                    end else if (is_out) begin
                        a_out  = 1'b1;
                        out_in = 1'b1;
                    end
                end
                T5: begin
                    if (is_lda || is_arith) begin
                        ir_drive = 1'b1;
                        mar_in   = 1'b1;
                    end else if (is_jmp) begin
                        ir_drive = 1'b1;
                        pc_load  = 1'b1;
                    end
                end
                T6: begin
                    if (is_lda) begin
                        ram_out = 1'b1;
                        a_in    = 1'b1;
                    end else if (is_arith) begin
                        ram_out = 1'b1;
                        b_in    = 1'b1;
                        alu_sub = is_sub;
                    end
                end
                T7: begin
                    if (is_arith) begin
                        alu_out = 1'b1;
                        a_in    = 1'b1;
                        alu_sub = is_sub;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Debug and status outputs. During reset these show the T1 restart point.
    always_comb begin
        t_state = reset ? 3'd1 : state_q;
        halted  = !reset && (state_q == HALT);
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer. Every cycle it checks the full
// output vector {halted, t_state, strobes} against hand-derived values.
// A background monitor confirms that at most one bus driver is high.

module tb_controller_sequencer;

    logic       clock;
    logic       reset;
    logic [3:0] opcode;
    logic       pc_out, pc_inc, pc_load, mar_in, ram_out, ir_in, ir_out;
    logic       ir_drive, a_in, a_out, b_in, alu_out, alu_sub, out_in;
    logic [2:0] t_state;
    logic       halted;

    int checks = 0;
    int errors = 0;
    bit monitor_on = 1'b0;

    // Strobe bit positions inside the 14-bit strobe field
    localparam logic [13:0] S_PCO  = 14'h2000;
    localparam logic [13:0] S_PCI  = 14'h1000;
    localparam logic [13:0] S_PCL  = 14'h0800;
    localparam logic [13:0] S_MARI = 14'h0400;
    localparam logic [13:0] S_RAMO = 14'h0200;
    localparam logic [13:0] S_IRI  = 14'h0100;
    localparam logic [13:0] S_IRO  = 14'h0080;
    localparam logic [13:0] S_IRD  = 14'h0040;
    localparam logic [13:0] S_AI   = 14'h0020;
    localparam logic [13:0] S_AO   = 14'h0010;
    localparam logic [13:0] S_BI   = 14'h0008;
    localparam logic [13:0] S_ALUO = 14'h0004;
    localparam logic [13:0] S_SUB  = 14'h0002;
    localparam logic [13:0] S_OUTI = 14'h0001;
    localparam logic [13:0] S_NONE = 14'h0000;

    controller_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .opcode   (opcode),
        .pc_out   (pc_out),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .mar_in   (mar_in),
        .ram_out  (ram_out),
        .ir_in    (ir_in),
        .ir_out   (ir_out),
        .ir_drive (ir_drive),
        .a_in     (a_in),
        .a_out    (a_out),
        .b_in     (b_in),
        .alu_out  (alu_out),
        .alu_sub  (alu_sub),
        .out_in   (out_in),
        .t_state  (t_state),
        .halted   (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Check one cycle's outputs, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        #1;
        obs = {halted, t_state, pc_out, pc_inc, pc_load, mar_in, ram_out, ir_in,
               ir_out, ir_drive, a_in, a_out, b_in, alu_out, alu_sub, out_in};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_t1"}, {1'b0, 3'd1, S_PCO | S_MARI});
        cyc({tag, "_t2"}, {1'b0, 3'd2, S_PCI});
        cyc({tag, "_t3"}, {1'b0, 3'd3, S_RAMO | S_IRI});
    endtask

    always @(negedge clock) begin
        if (monitor_on) begin
            checks++;
            assert ($onehot0({pc_out, ram_out, ir_drive, a_out, alu_out})) else begin
                errors++;
                $error("FAIL bus_excl: observed %b expected at most one high",
                       {pc_out, ram_out, ir_drive, a_out, alu_out});
            end
        end
    end

    initial begin
        reset  = 1'b1;
        opcode = 4'b0000;
        @(posedge clock);
        #1;
        monitor_on = 1'b1;

        // Reset held for three cycles
        cyc("rst0", {1'b0, 3'd1, S_NONE});
        cyc("rst1", {1'b0, 3'd1, S_NONE});
        cyc("rst2", {1'b0, 3'd1, S_NONE});
        reset = 1'b0;

        // LDA: 6 clocks
        opcode = 4'b0000;
        fetch("lda");
        cyc("lda_t4", {1'b0, 3'd4, S_IRO});
        cyc("lda_t5", {1'b0, 3'd5, S_IRD | S_MARI});
        cyc("lda_t6", {1'b0, 3'd6, S_RAMO | S_AI});

        // SUB: 7 clocks, alu_sub in T6 and T7
        opcode = 4'b0010;
        fetch("sub");
        cyc("sub_t4", {1'b0, 3'd4, S_IRO});
        cyc("sub_t5", {1'b0, 3'd5, S_IRD | S_MARI});
        cyc("sub_t6", {1'b0, 3'd6, S_RAMO | S_BI | S_SUB});
        cyc("sub_t7", {1'b0, 3'd7, S_ALUO | S_AI | S_SUB});

        // ADD: 7 clocks, alu_sub low
        opcode = 4'b0001;
        fetch("add");
        cyc("add_t4", {1'b0, 3'd4, S_IRO});
        cyc("add_t5", {1'b0, 3'd5, S_IRD | S_MARI});
        cyc("add_t6", {1'b0, 3'd6, S_RAMO | S_BI});
        cyc("add_t7", {1'b0, 3'd7, S_ALUO | S_AI});

        // OUT: 4 clocks
        opcode = 4'b1110;
        fetch("out");
        cyc("out_t4", {1'b0, 3'd4, S_AO | S_OUTI});

        // JMP: 5 clocks when enabled, otherwise a 4-clock NOP
        opcode = 4'b0011;
        fetch("jmp");
`ifdef SAP_JMP_EN
        cyc("jmp_t4", {1'b0, 3'd4, S_IRO});
        cyc("jmp_t5", {1'b0, 3'd5, S_IRD | S_PCL});
`else
        cyc("jmp_t4", {1'b0, 3'd4, S_NONE});
`endif

        // Unassigned opcode: NOP
        opcode = 4'b0101;
        fetch("nop");
        cyc("nop_t4", {1'b0, 3'd4, S_NONE});

        // HLT: T4 silent, then HALT indefinitely
        opcode = 4'b1111;
        fetch("hlt");
        cyc("hlt_t4", {1'b0, 3'd4, S_NONE});
        for (int i = 0; i < 22; i++) begin
            cyc("halt", {1'b1, 3'd0, S_NONE});
        end

        // Reset pulse leaves HALT
        reset = 1'b1;
        cyc("halt_rst", {1'b0, 3'd1, S_NONE});
        reset  = 1'b0;
        opcode = 4'b0001;

        // ADD interrupted by reset in T6
        fetch("radd");
        cyc("radd_t4", {1'b0, 3'd4, S_IRO});
        cyc("radd_t5", {1'b0, 3'd5, S_IRD | S_MARI});
        reset = 1'b1;
        cyc("radd_t6rst", {1'b0, 3'd1, S_NONE});
        reset = 1'b0;
        cyc("radd_after_t1", {1'b0, 3'd1, S_PCO | S_MARI});
        cyc("radd_after_t2", {1'b0, 3'd2, S_PCI});

        monitor_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 controller-sequencer: consumes the 4-bit opcode presented by the instruction register and generates every per-cycle control strobe for PC, MAR, RAM, IR, A, B, ALU and output register. It is the opposite end of the IR/controller interface: it drives `ir_in` and `ir_out` into the IR and reads back its upper nibble. It is built around a variable-length T-state machine, from fetch through execute, and halts on HLT.

## Interface
- `OP_LDA`, default 4'b0000, load A from RAM[operand]
- `OP_ADD`, default 4'b0001, A <= A + RAM[operand]
- `OP_SUB`, default 4'b0010, A <= A - RAM[operand]
- `OP_JMP`, default 4'b0011, PC <= operand (only with `SAP_JMP_EN`)
- `OP_OUT`, default 4'b1110, OUT <= A
- `OP_HLT`, default 4'b1111, stop
- Ports:
  - `clock`  in  1  single system clock, rising edge
  - `reset`  in  1  synchronous, active-high
  - `opcode`  in  4  IR upper nibble; valid from T4 onward
  - `pc_out`, `pc_inc`, `pc_load`  out  1 each  PC bus drive / increment / load-from-bus
  - `mar_in`  out  1  MAR load from bus
  - `ram_out`  out  1  RAM drives bus
  - `ir_in`  out  1  IR loads bus
  - `ir_out`  out  1  IR registers operand into its bus output (takes effect next edge)
  - `ir_drive`  out  1  bus mux selects IR bus output
  - `a_in`, `a_out`, `b_in`  out  1 each  A load / A drive / B load
  - `alu_out`, `alu_sub`  out  1 each  ALU drives bus / subtract mode
  - `out_in`  out  1  output register load
  - `t_state`  out  3  current state encoding (debug)
  - `halted`  out  1  high in HALT

## Operation
- The state register holds T1..T7 (encoded 3'd1..3'd7) or HALT (3'd0). Outputs are decoded combinationally from the state and `opcode`. All strobes not listed for a state are 0.
- **Operand pre-drive rule:**
  - The IR bus output is registered, so `ir_out` is asserted one state before the operand is consumed.
  - `ir_drive` is asserted in the consuming state.
- Fetch, identical for all opcodes:
  - T1: `pc_out`, `mar_in`
  - T2: `pc_inc`
  - T3: `ram_out`, `ir_in`
- Execute sequences:
  - **LDA:**
    - T4: `ir_out`
    - T5: `ir_drive`, `mar_in`
    - T6: `ram_out`, `a_in`, then T1
  - **ADD:**
    - T4: `ir_out`
    - T5: `ir_drive`, `mar_in`
    - T6: `ram_out`, `b_in`
    - T7: `alu_out`, `a_in`, then T1
  - **SUB:** as ADD, with `alu_sub`=1 in T6 and T7.
  - **OUT:** T4: `a_out`, `out_in`, then T1.
  - **HLT:** T4: no strobes, then HALT. HALT holds with all strobes 0 and `halted`=1 until `reset`.
  - **Any other opcode (NOP):** T4 with no strobes, then T1.
- Only one bus driver is ever asserted per state: `pc_out`, `ram_out`, `ir_drive`, `a_out`, `alu_out` are mutually exclusive.

## Timing
- **Reset:**
  - `reset` high at a rising edge forces the state to T1.
  - While `reset` is high, all strobe outputs are forced to 0, `halted`=0 and `t_state`=3'd1.
  - The first fetch strobes appear in the first cycle with `reset` low.
- **Reset mid-instruction:** any state, including HALT, goes to T1 on the next edge. No partial execute strobe is emitted during the reset cycle.
- **Opcode sampling:**
  - `opcode` is read in T4..T7 only and ignored in T1..T3.
  - The IR must not change after T3 until the next T3.
- Instruction lengths in clocks:
  - LDA 6
  - ADD/SUB 7
  - OUT 4
  - NOP 4
  - JMP 5
  - HLT 4 to reach HALT
- State advances on every rising edge; there are no stall inputs.

## Configuration
- Macro: `SAP_JMP_EN`.
- **With `SAP_JMP_EN` defined:**
  - `OP_JMP`:
    - T4: `ir_out`
    - T5: `ir_drive`, `pc_load`, then T1
  - `pc_load` is otherwise 0.
- **Without `SAP_JMP_EN`:**
  - `OP_JMP` decodes as NOP (4 clocks).
  - `pc_load` is tied to 0.

## Test plan
- Reset held 3 cycles, then released -> all strobes 0 during reset. First released cycle: `t_state`=1, `pc_out`=`mar_in`=1. Next cycle `pc_inc`=1, then `ram_out`=`ir_in`=1.
- `opcode`=4'b0000 -> T4 `ir_out` only; T5 `ir_drive`+`mar_in`; T6 `ram_out`+`a_in`; T1 follows; 6-clock period.
- `opcode`=4'b0010 -> T6 `ram_out`+`b_in`+`alu_sub`; T7 `alu_out`+`a_in`+`alu_sub`; return to T1 after 7 clocks. Same check with 4'b0001 and `alu_sub`=0.
- `opcode`=4'b1110 then 4'b1111 -> OUT T4 `a_out`+`out_in`. HLT reaches HALT, `halted`=1 and all strobes 0 for 20+ cycles. `reset` pulse returns to T1 with `halted`=0.
- `reset` asserted in T6 of ADD -> no `alu_out`/`a_in` strobe is emitted; state is T1 after the edge.
- `opcode`=4'b0011: with `SAP_JMP_EN`, T5 shows `ir_drive`+`pc_load`, 5 clocks. Without it, no strobes in T4 and a 4-clock NOP. Every build: at most one bus driver high in every cycle.
